textbuf_port2_sequencer: RTL

- Owns port 2 of the 4096x8 dual-port text buffer RAM. Port 1 stays on the HPS Avalon bridge.
- Shares port 2 between two requesters:
  - the VGA character fetcher: read-only, strict priority;
  - an internal block-operation engine: clear screen, scroll up one row.
- Sits between the VGA text renderer and the RAM's s2 interface. HPS software launches engine commands through a small command handshake.

---
 rtl/textbuf_port2_sequencer_if.sv | 35 +++
 rtl/textbuf_port2_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/textbuf_port2_sequencer_if.sv
// Port bundle of textbuf_port2_sequencer: command handshake, VGA read port and RAM port 2.
// master = the sequencer, slave = its environment (renderer, HPS command side, RAM).
interface textbuf_port2_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_fill;
    logic              busy;
    logic              done;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic [ADDR_W-1:0] mem_address2;
    logic              mem_chipselect2;
    logic              mem_write2;
    logic [DATA_W-1:0] mem_writedata2;
    logic              mem_clken2;
    logic [DATA_W-1:0] mem_readdata2;

    modport master (
        input  cmd_valid, cmd_op, cmd_fill, vga_req, vga_addr, mem_readdata2,
        output cmd_ready, busy, done, vga_rdata, vga_rvalid,
               mem_address2, mem_chipselect2, mem_write2, mem_writedata2, mem_clken2
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_fill, vga_req, vga_addr, mem_readdata2,
        input  cmd_ready, busy, done, vga_rdata, vga_rvalid,
               mem_address2, mem_chipselect2, mem_write2, mem_writedata2, mem_clken2
    );
endinterface

// File: rtl/textbuf_port2_sequencer.sv
// Owns port 2 of the text buffer: VGA reads win every cycle, the clear/scroll engine uses
// the remaining cycles. Defining TEXTBUF_STALL_CNT_EN adds the stall_count output.
module textbuf_port2_sequencer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef TEXTBUF_STALL_CNT_EN
    output logic [15:0] stall_count,
`endif
    textbuf_port2_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_SCR_RD   = 3'd2;
    localparam logic [2:0] S_SCR_WR   = 3'd3;
    localparam logic [2:0] S_SCR_FILL = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_OFS   = ADDR_W'(COLS);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              cap_pend_q, cap_pend_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

    logic              eng_pending;
    logic              eng_grant;
    logic              accept;
    logic [DATA_W-1:0] scroll_byte;

    assign eng_pending = (state_q == S_CLEAR) || (state_q == S_SCR_RD) ||
                         (state_q == S_SCR_WR) || (state_q == S_SCR_FILL);
    // A reset cycle never lets the engine write, so an aborted op leaves ptr and above untouched.
    assign eng_grant   = eng_pending && !bus.vga_req && !reset;
    assign accept      = bus.cmd_valid && !eng_pending;

    assign bus.busy       = eng_pending;
    assign bus.cmd_ready  = !eng_pending;
    assign bus.done       = (state_q == S_FIN);
    assign bus.mem_clken2 = 1'b1;
    assign bus.vga_rvalid = rvalid_q;
    assign bus.vga_rdata  = rdata_hold_d;

    // The scroll read data sits on the RAM output only in the cycle after the read;
    // an immediate write takes it straight from there, a stalled one from the capture reg.
    assign scroll_byte = cap_pend_q ? bus.mem_readdata2 : cap_data_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        cap_pend_d = 1'b0;
        cap_data_d = scroll_byte;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (accept) begin
                    fill_d = bus.cmd_fill;
                    ptr_d  = '0;
                    case (bus.cmd_op)
                        2'b00:   state_d = S_CLEAR;
                        2'b01:   state_d = S_SCR_RD;
                        default: state_d = S_FIN;
                    endcase
                end
            end
            S_CLEAR, S_SCR_FILL: begin
                if (eng_grant) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) state_d = S_FIN;
                end
            end
            S_SCR_RD: begin
                if (eng_grant) begin
                    cap_pend_d = 1'b1;
                    state_d    = S_SCR_WR;
                end
            end
            S_SCR_WR: begin
                if (eng_grant) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = (ptr_q == SCR_LAST) ? S_SCR_FILL : S_SCR_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_address2    = '0;
        bus.mem_chipselect2 = 1'b0;
        bus.mem_write2      = 1'b0;
        bus.mem_writedata2  = '0;
        if (bus.vga_req) begin
            bus.mem_address2    = bus.vga_addr;
            bus.mem_chipselect2 = 1'b1;
        end else if (eng_grant) begin
            bus.mem_chipselect2 = 1'b1;
            case (state_q)
                S_SCR_RD: bus.mem_address2 = ptr_q + ROW_OFS;
                S_SCR_WR: begin
                    bus.mem_address2   = ptr_q;
                    bus.mem_write2     = 1'b1;
                    bus.mem_writedata2 = scroll_byte;
                end
                default: begin
                    bus.mem_address2   = ptr_q;
                    bus.mem_write2     = 1'b1;
                    bus.mem_writedata2 = fill_q;
                end
            endcase
        end
    end

    always_comb begin
        rvalid_d     = bus.vga_req;
        rdata_hold_d = rvalid_q ? bus.mem_readdata2 : rdata_hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            fill_q       <= '0;
            cap_pend_q   <= 1'b0;
            cap_data_q   <= '0;
            rvalid_q     <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            fill_q       <= fill_d;
            cap_pend_q   <= cap_pend_d;
            cap_data_q   <= cap_data_d;
            rvalid_q     <= rvalid_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

`ifdef TEXTBUF_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (eng_pending && bus.vga_req && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif
endmodule
